seq_div_16: RTL and testbench

SEQ_DIV_16 -- requirements
Module: seq_div_16

---
 rtl/seq_div_16.sv | 132 +++++++++++++
 tb/tb_seq_div_16.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_div_16.sv
// Sequential restoring divider: one quotient bit per clock, WIDTH steps per division.
// Results, busy, done and div_by_zero are all registered; start is honoured in IDLE or DONE.
module seq_div_16 #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;

  // One restoring step; dvd_q shifts out dividend bits and shifts in quotient bits.
  logic [WIDTH+1:0] rem_shift;
  logic [WIDTH+1:0] trial;
  logic             sub_ok;
  logic [WIDTH:0]   rem_step;
  logic [WIDTH-1:0] quo_step;

  always_comb begin
    rem_shift = {rem_q, dvd_q[WIDTH-1]};
    trial     = rem_shift - {2'b00, dvs_q};
    sub_ok    = ~trial[WIDTH+1];
    rem_step  = sub_ok ? trial[WIDTH:0] : rem_shift[WIDTH:0];
    quo_step  = {dvd_q[WIDTH-2:0], sub_ok};
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          dvd_d   = dividend;
          dvs_d   = divisor;
          rem_d   = '0;
          cnt_d   = CW'(WIDTH);
          busy_d  = 1'b1;
          state_d = RUN;
        end else begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      RUN: begin
        rem_d = rem_step;
        dvd_d = quo_step;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          // Divisor 0 naturally yields all-ones quotient and remainder = dividend.
          quotient_d  = quo_step;
          remainder_d = rem_step[WIDTH-1:0];
          dbz_d       = (dvs_q == '0);
          busy_d      = 1'b0;
          done_d      = 1'b1;
          state_d     = DONE;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_div_16.sv
// Bench for seq_div_16: vector table, hand-written corner sequences and random
// divisions checked against plain integer division.
module tb_seq_div_16;

  localparam int unsigned WIDTH = 16;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  int n_checks;
  int n_fails;

  // Output values the bench expects to be held between result updates.
  logic [WIDTH-1:0] hold_q;
  logic [WIDTH-1:0] hold_r;
  logic             hold_z;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             z;
  } vec_t;

  vec_t vecs [6];

  seq_div_16 #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integer division with the divide-by-zero rule.
  task automatic model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       output logic [WIDTH-1:0] q, output logic [WIDTH-1:0] r,
                       output logic z);
    if (b == 0) begin
      q = '1;
      r = a;
      z = 1'b1;
    end else begin
      q = a / b;
      r = a % b;
      z = 1'b0;
    end
  endtask

  // Presents operands with start before the next rising edge (edge N), then scrambles them.
  task automatic accept(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = WIDTH'($urandom);
    divisor  = WIDTH'($urandom);
    chk("busy_after_accept", 32'(busy), 32'd1);
    chk("done_after_accept", 32'(done), 32'd0);
  endtask

  // Runs edges N+1..N+WIDTH; optionally pulses start with 50/5 before edge N+inject.
  task automatic finish(input string name, input logic [WIDTH-1:0] eq, input logic [WIDTH-1:0] er,
                        input logic ez, input int inject);
    int busy_cnt;
    bit held;
    busy_cnt = 1;
    held     = 1'b1;
    for (int k = 1; k <= int'(WIDTH); k++) begin
      if (k == inject) begin
        @(negedge clk);
        start    = 1'b1;
        dividend = 16'd50;
        divisor  = 16'd5;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      if (k < int'(WIDTH)) begin
        if (busy && !done) busy_cnt++;
        if (quotient !== hold_q || remainder !== hold_r || div_by_zero !== hold_z) held = 1'b0;
      end
    end
    chk({name, "_busy_cycles"}, 32'(busy_cnt), 32'(WIDTH));
    chk({name, "_held"}, 32'(held), 32'd1);
    chk({name, "_done"}, 32'(done), 32'd1);
    chk({name, "_busy_end"}, 32'(busy), 32'd0);
    chk({name, "_q"}, 32'(quotient), 32'(eq));
    chk({name, "_r"}, 32'(remainder), 32'(er));
    chk({name, "_dbz"}, 32'(div_by_zero), 32'(ez));
    hold_q = eq;
    hold_r = er;
    hold_z = ez;
  endtask

  // One cycle after done: pulse gone, block idle, results held.
  task automatic after_done(input string name);
    @(posedge clk);
    #1;
    chk({name, "_done_gone"}, 32'(done), 32'd0);
    chk({name, "_idle"}, 32'(busy), 32'd0);
    chk({name, "_hold_q"}, 32'(quotient), 32'(hold_q));
  endtask

  task automatic count_done(input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
  endtask

  initial begin
    logic [WIDTH-1:0] a, b, eq, er;
    logic ez;
    int pulses;

    n_checks = 0;
    n_fails  = 0;
    hold_q   = '0;
    hold_r   = '0;
    hold_z   = 1'b0;
    vecs[0] = '{a: 16'd100,   b: 16'd7,  q: 16'd14,   r: 16'd2,  z: 1'b0};
    vecs[1] = '{a: 16'hFFFF,  b: 16'd1,  q: 16'hFFFF, r: 16'd0,  z: 1'b0};
    vecs[2] = '{a: 16'd3,     b: 16'd10, q: 16'd0,    r: 16'd3,  z: 1'b0};
    vecs[3] = '{a: 16'd5,     b: 16'd0,  q: 16'hFFFF, r: 16'd5,  z: 1'b1};
    vecs[4] = '{a: 16'd9,     b: 16'd3,  q: 16'd3,    r: 16'd0,  z: 1'b0};
    vecs[5] = '{a: 16'd1000,  b: 16'd33, q: 16'd30,   r: 16'd10, z: 1'b0};

    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #23;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_q", 32'(quotient), 32'd0);
    chk("rst_r", 32'(remainder), 32'd0);
    chk("rst_dbz", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Vector table, each division run to completion.
    for (int i = 0; i < 6; i++) begin
      accept(vecs[i].a, vecs[i].b);
      finish($sformatf("vec%0d", i), vecs[i].q, vecs[i].r, vecs[i].z, 0);
      after_done($sformatf("vec%0d", i));
    end

    // Start pulsed mid-run is ignored; exactly one done follows.
    accept(16'd100, 16'd7);
    finish("ignore_start", 16'd14, 16'd2, 1'b0, 5);
    count_done(20, pulses);
    chk("ignore_start_no_2nd_done", 32'(pulses), 32'd0);

    // Reset during a run: outputs clear immediately, no done, first edge after release accepts.
    accept(16'd100, 16'd7);
    repeat (7) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_q", 32'(quotient), 32'd0);
    chk("abort_r", 32'(remainder), 32'd0);
    hold_q = '0;
    hold_r = '0;
    hold_z = 1'b0;
    count_done(3, pulses);
    @(negedge clk);
    rst_n = 1'b1;
    count_done(20, pulses);
    chk("abort_no_done", 32'(pulses), 32'd0);
    rst_n = 1'b0;
    #7;
    @(negedge clk);
    rst_n    = 1'b1;
    start    = 1'b1;
    dividend = 16'd1000;
    divisor  = 16'd33;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("first_edge_accept", 32'(busy), 32'd1);
    finish("post_reset", 16'd30, 16'd10, 1'b0, 0);

    // Back-to-back: start held during the done cycle starts 65535/255 on that edge.
    accept(16'd65535, 16'd255);
    finish("b2b_prev", 16'd257, 16'd0, 1'b0, 0);
    @(negedge clk);
    start    = 1'b1;
    dividend = 16'd65535;
    divisor  = 16'd255;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("b2b_done_gone", 32'(done), 32'd0);
    chk("b2b_busy", 32'(busy), 32'd1);
    finish("b2b", 16'd257, 16'd0, 1'b0, 0);
    after_done("b2b");

    // Random divisions against the model, including zero and small divisors.
    for (int i = 0; i < 40; i++) begin
      a = WIDTH'($urandom);
      case ($urandom_range(0, 3))
        0: b = '0;
        1: b = WIDTH'($urandom_range(1, 15));
        default: b = WIDTH'($urandom);
      endcase
      model(a, b, eq, er, ez);
      accept(a, b);
      finish($sformatf("rand%0d", i), eq, er, ez, 0);
    end
    after_done("rand_end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

endmodule
